// File: rtl/nrad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nrad_pkg
// Brief    : Shared widths, error codes and FSM encoding for the NRAD sequencer
// Revision : 1.0
// ============================================================================
package nrad_pkg;

  localparam int NRAD_X_W  = 4;
  localparam int NRAD_Y_W  = 2;
  localparam int NRAD_QR_W = 3;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seq_state_t;

  // Quotient would need more than NRAD_QR_W bits: x >= 8*y in 5 bits
  function automatic logic is_ovf(logic [NRAD_X_W-1:0] x, logic [NRAD_Y_W-1:0] y);
    return {1'b0, x} >= {y, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nrad_op_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nrad_op_fifo
// Brief    : Synchronous operand FIFO with full/empty/count status
// Revision : 1.0
// ============================================================================
module nrad_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/nrad_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nrad_op_sequencer
// Brief    : Issues buffered {x,y} pairs to the NRAD divider and retires Q/R
// Revision : 1.0
// ============================================================================
module nrad_op_sequencer
  import nrad_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NRAD_X_W-1:0]  in_x,
  input  logic [NRAD_Y_W-1:0]  in_y,
  output logic [NRAD_X_W-1:0]  div_x,
  output logic [NRAD_Y_W-1:0]  div_y,
  input  logic [NRAD_QR_W-1:0] div_q,
  input  logic [NRAD_QR_W-1:0] div_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NRAD_QR_W-1:0] out_q,
  output logic [NRAD_QR_W-1:0] out_r,
  output logic [1:0]           out_err,
  output logic                 busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = NRAD_X_W + NRAD_Y_W;

  seq_state_t             r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [NRAD_X_W-1:0]    r_div_x, w_div_x_nxt;
  logic [NRAD_Y_W-1:0]    r_div_y, w_div_y_nxt;
  logic [NRAD_QR_W-1:0]   r_q, w_q_nxt;
  logic [NRAD_QR_W-1:0]   r_r, w_r_nxt;
  logic [1:0]             r_err, w_err_nxt;
  logic                   r_valid, w_valid_nxt;

  logic                   w_pop;
  logic [EW-1:0]          w_head;
  logic [NRAD_X_W-1:0]    w_head_x;
  logic [NRAD_Y_W-1:0]    w_head_y;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;

  nrad_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (w_pop),
    .wdata ({in_x, in_y}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign {w_head_x, w_head_y} = w_head;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign in_ready  = !w_full;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);

  assign div_x     = r_div_x;
  assign div_y     = r_div_y;
  assign out_q     = r_q;
  assign out_r     = r_r;
  assign out_err   = r_err;
  assign out_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div_x <= '0;
      r_div_y <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_err   <= ERR_OK;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div_x <= w_div_x_nxt;
      r_div_y <= w_div_y_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_err   <= w_err_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_x_nxt = r_div_x;
    w_div_y_nxt = r_div_y;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_err_nxt   = r_err;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          // Error cases retire directly and leave the array inputs untouched
          if (w_head_y == '0) begin
            w_q_nxt     = '1;
            w_r_nxt     = '0;
            w_err_nxt   = ERR_DIV0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (is_ovf(w_head_x, w_head_y)) begin
            w_q_nxt     = '1;
            w_r_nxt     = '0;
            w_err_nxt   = ERR_OVF;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_div_x_nxt = w_head_x;
            w_div_y_nxt = w_head_y;
            w_cnt_nxt   = CW'(SETTLE - 1);
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_q_nxt     = div_q;
          w_r_nxt     = div_r;
          w_err_nxt   = ERR_OK;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nrad_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nrad_op_sequencer
// Brief    : Self-checking bench with a behavioural NRAD array beside the DUT
// Revision : 1.0
// ============================================================================
module tb_nrad_op_sequencer;
  import nrad_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = '0;
  logic [1:0] in_y = '0;
  logic [3:0] div_x;
  logic [1:0] div_y;
  logic [2:0] div_q;
  logic [2:0] div_r;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_q;
  logic [2:0] out_r;
  logic [1:0] out_err;
  logic       busy;

  always #5 clk = ~clk;

  nrad_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .div_x(div_x), .div_y(div_y),
    .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_err(out_err), .busy(busy)
  );

  // Array stand-in: outputs are corrupted during the cycle after its inputs change
  logic [5:0] nrad_prev = '0;
  always @(posedge clk) nrad_prev <= {div_x, div_y};
  always_comb begin
    int qi, ri;
    qi = 0;
    ri = 0;
    if (div_y != 0) begin
      qi = int'(div_x) / int'(div_y);
      ri = int'(div_x) % int'(div_y);
    end
    div_q = 3'(qi);
    div_r = 3'(ri);
    if ({div_x, div_y} != nrad_prev) begin
      div_q = div_q ^ 3'b101;
      div_r = div_r ^ 3'b011;
    end
  end

  typedef struct packed {
    logic [2:0] q;
    logic [2:0] r;
    logic [1:0] e;
  } res_t;

  typedef struct {
    int x; int y; int q; int r; int e; int lat;
  } vec_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t ref_div(int x, int y);
    res_t res;
    if (y == 0) begin
      res.q = 3'd7; res.r = 3'd0; res.e = 2'b01;
    end else if (x / y > 7) begin
      res.q = 3'd7; res.r = 3'd0; res.e = 2'b10;
    end else begin
      res.q = 3'(x / y); res.r = 3'(x % y); res.e = 2'b00;
    end
    return res;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int x, int y);
    in_valid = 1'b1;
    in_x = 4'(x);
    in_y = 2'(y);
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    chk("push_accept", int'(in_ready), 1);
    exp_q.push_back(ref_div(x, y));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Retirement scoreboard plus hold-stability check
  logic       pv = 1'b0;
  logic [2:0] pq = '0, pr = '0;
  logic [1:0] pe = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
    end else begin
      if (pv) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_q", int'(out_q), int'(pq));
        chk("hold_r", int'(out_r), int'(pr));
        chk("hold_err", int'(out_err), int'(pe));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got q=%0d r=%0d err=%0d expected none", out_q, out_r, out_err);
        end else begin
          chk("ret_q", int'(out_q), int'(exp_q[0].q));
          chk("ret_r", int'(out_r), int'(exp_q[0].r));
          chk("ret_err", int'(out_err), int'(exp_q[0].e));
          void'(exp_q.pop_front());
        end
      end
      pv <= out_valid && !out_ready;
      pq <= out_q;
      pr <= out_r;
      pe <= out_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   n;
    logic [3:0] dx;
    logic [1:0] dy;

    vecs[0]  = '{13, 3, 4, 1, 0, 3};
    vecs[1]  = '{ 5, 0, 7, 0, 1, 1};
    vecs[2]  = '{ 9, 1, 7, 0, 2, 1};
    vecs[3]  = '{ 7, 1, 7, 0, 0, 3};
    vecs[4]  = '{ 8, 3, 2, 2, 0, 3};
    vecs[5]  = '{15, 3, 5, 0, 0, 3};
    vecs[6]  = '{ 0, 2, 0, 0, 0, 3};
    vecs[7]  = '{ 8, 1, 7, 0, 2, 1};
    vecs[8]  = '{15, 1, 7, 0, 2, 1};
    vecs[9]  = '{ 6, 1, 6, 0, 0, 3};
    vecs[10] = '{15, 2, 7, 1, 0, 3};
    vecs[11] = '{ 0, 0, 7, 0, 1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_div_x", int'(div_x), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    tick();

    // Table: one pair at a time, latency and value per vector
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b0;
      dx = div_x;
      dy = div_y;
      push(vecs[i].x, vecs[i].y);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      chk($sformatf("vec%0d_latency", i), n, vecs[i].lat);
      chk($sformatf("vec%0d_q", i), int'(out_q), vecs[i].q);
      chk($sformatf("vec%0d_r", i), int'(out_r), vecs[i].r);
      chk($sformatf("vec%0d_err", i), int'(out_err), vecs[i].e);
      if (vecs[i].e != 0) begin
        chk($sformatf("vec%0d_divx_kept", i), int'(div_x), int'(dx));
        chk($sformatf("vec%0d_divy_kept", i), int'(div_y), int'(dy));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Backpressure: fill FIFO behind a held result, then drain in order
    out_ready = 1'b0;
    push(14, 3); push(6, 2); push(15, 2); push(3, 3); push(10, 3);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_busy", int'(busy), 1);
    out_ready = 1'b1;
    tick();
    chk("full_pop_pending_in_ready", int'(in_ready), 0);
    drain("bp_drain");

    // Long hold on one result
    out_ready = 1'b0;
    push(8, 3);
    repeat (13) tick();
    chk("long_hold_valid", int'(out_valid), 1);
    chk("long_hold_q", int'(out_q), 2);
    chk("long_hold_r", int'(out_r), 2);
    out_ready = 1'b1;
    drain("hold_drain");

    // Asynchronous reset in the middle of SETTLE with two entries queued
    out_ready = 1'b0;
    push(14, 3); push(6, 2); push(15, 2);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", int'(out_valid), 0);
    chk("ar_out_q", int'(out_q), 0);
    chk("ar_out_r", int'(out_r), 0);
    chk("ar_out_err", int'(out_err), 0);
    chk("ar_div_x", int'(div_x), 0);
    chk("ar_div_y", int'(div_y), 0);
    chk("ar_busy", int'(busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (10) tick();
    chk("ar_no_stale", int'(out_valid), 0);
    chk("ar_idle", int'(busy), 0);

    // Randomised traffic against the reference queue
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = 4'($urandom_range(0, 15));
      in_y      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) exp_q.push_back(ref_div(int'(in_x), int'(in_y)));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
